// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared constants and types for the binary16 datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS = 15;
    localparam logic [4:0] EXP_MAX = 5'h1F;

    // Two-bit explicitly encoded stage state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

endpackage
`default_nettype wire

// File: rtl/fp16_rne_inc.sv
`default_nettype none
// ============================================================================
// Module      : fp16_rne_inc
// Description : Round-to-nearest-even increment of an 11-bit significand.
//               Output carries one extra bit so the caller can renormalise.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_rne_inc
    import fp16_pkg::*;
#(
    parameter int FRAC_W = 10
) (
    input  logic [FRAC_W:0]   mant,
    input  logic              guard,
    input  logic              sticky,
    output logic [FRAC_W+1:0] rounded,
    output logic              inexact
);

    logic w_inc;

    // Round up above half, or exactly at half when the LSB is odd
    always_comb begin
        w_inc   = guard & (sticky | mant[0]);
        rounded = {1'b0, mant} + {{(FRAC_W + 1){1'b0}}, w_inc};
        inexact = guard | sticky;
    end

endmodule
`default_nettype wire

// File: rtl/fp16_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp16_norm_round
// Description : Sequential normalise-and-round stage for binary16. Shifts the
//               raw mantissa sum one position per cycle, then rounds to
//               nearest-even and packs the result with status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_norm_round
    import fp16_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W+1:0]       mant_in,
    input  logic                    guard_in,
    input  logic                    sticky_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    localparam int MW = FRAC_W + 2;   // {carry, hidden, frac}
    localparam int EW = EXP_W + 1;    // internal exponent, one spare bit
    localparam logic [EW-1:0]     c_E_ONE     = EW'(1);
    localparam logic [EW-1:0]     c_E_MAX     = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0]  c_EXP_ALL1  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  c_EXP_ONE   = EXP_W'(1);
    localparam logic [FRAC_W-1:0] c_FRAC_ZERO = '0;

    state_t                 r_state;
    logic                   r_sign;
    logic [MW-1:0]          r_mant;
    logic                   r_guard;
    logic                   r_sticky;
    logic [EW-1:0]          r_e;
    logic                   r_sub;
    logic [EXP_W+FRAC_W:0]  r_result;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   r_inexact;

    state_t                 w_state_nxt;
    logic                   w_sign_nxt;
    logic [MW-1:0]          w_mant_nxt;
    logic                   w_guard_nxt;
    logic                   w_sticky_nxt;
    logic [EW-1:0]          w_e_nxt;
    logic                   w_sub_nxt;
    logic [EXP_W+FRAC_W:0]  w_result_nxt;
    logic                   w_overflow_nxt;
    logic                   w_underflow_nxt;
    logic                   w_inexact_nxt;

    logic [FRAC_W+1:0]      w_rounded;
    logic                   w_rnd_inexact;
    logic [EW-1:0]          w_e_adj;
    logic [FRAC_W-1:0]      w_frac_rnd;
    logic [EXP_W-1:0]       w_exp_fld;

    fp16_rne_inc #(
        .FRAC_W (FRAC_W)
    ) u_rne_inc (
        .mant    (r_mant[FRAC_W:0]),
        .guard   (r_guard),
        .sticky  (r_sticky),
        .rounded (w_rounded),
        .inexact (w_rnd_inexact)
    );

    // Renormalise after a rounding carry and pick the packed exponent field
    always_comb begin
        if (w_rounded[FRAC_W+1]) begin
            w_frac_rnd = w_rounded[FRAC_W:1];
            w_e_adj    = r_e + c_E_ONE;
        end else begin
            w_frac_rnd = w_rounded[FRAC_W-1:0];
            w_e_adj    = r_e;
        end
        // A subnormal that rounds into the hidden bit becomes the smallest normal
        if (r_sub) begin
            w_exp_fld = w_rounded[FRAC_W] ? c_EXP_ONE : '0;
        end else begin
            w_exp_fld = w_e_adj[EXP_W-1:0];
        end
    end

    // Next-state and datapath update: one shift or decision per cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_sign_nxt      = r_sign;
        w_mant_nxt      = r_mant;
        w_guard_nxt     = r_guard;
        w_sticky_nxt    = r_sticky;
        w_e_nxt         = r_e;
        w_sub_nxt       = r_sub;
        w_result_nxt    = r_result;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_inexact_nxt   = r_inexact;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sign_nxt   = sign_in;
                    w_mant_nxt   = mant_in;
                    w_guard_nxt  = guard_in;
                    w_sticky_nxt = sticky_in;
                    w_sub_nxt    = 1'b0;
                    // Denormal inputs share the exponent of the smallest normal
                    w_e_nxt      = (exp_in == '0) ? c_E_ONE : {1'b0, exp_in};
                    if (exp_in == c_EXP_ALL1) begin
                        // Inf/NaN pass straight through with the payload intact
                        w_result_nxt    = {sign_in, c_EXP_ALL1, mant_in[FRAC_W-1:0]};
                        w_overflow_nxt  = 1'b0;
                        w_underflow_nxt = 1'b0;
                        w_inexact_nxt   = 1'b0;
                        w_state_nxt     = DONE;
                    end else begin
                        w_state_nxt = NORM;
                    end
                end
            end

            NORM: begin
                if (r_mant[MW-1]) begin
                    w_mant_nxt   = {1'b0, r_mant[MW-1:1]};
                    w_sticky_nxt = r_sticky | r_guard;
                    w_guard_nxt  = r_mant[0];
                    w_e_nxt      = r_e + c_E_ONE;
                end else if (r_mant[MW-2]) begin
                    w_state_nxt = ROUND;
                end else if ((r_mant == '0) && !r_guard) begin
                    w_result_nxt    = {r_sign, {(EXP_W + FRAC_W){1'b0}}};
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                    w_inexact_nxt   = 1'b0;
                    w_state_nxt     = DONE;
                end else if (r_e == c_E_ONE) begin
                    w_sub_nxt   = 1'b1;
                    w_state_nxt = ROUND;
                end else begin
                    w_mant_nxt  = {r_mant[MW-2:0], r_guard};
                    w_guard_nxt = 1'b0;
                    w_e_nxt     = r_e - c_E_ONE;
                end
            end

            ROUND: begin
                w_inexact_nxt = w_rnd_inexact;
                if (w_e_adj >= c_E_MAX) begin
                    w_result_nxt    = {r_sign, c_EXP_ALL1, c_FRAC_ZERO};
                    w_overflow_nxt  = 1'b1;
                    w_underflow_nxt = 1'b0;
                end else begin
                    w_result_nxt    = {r_sign, w_exp_fld, w_frac_rnd};
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = w_rnd_inexact & (w_exp_fld == '0);
                end
                w_state_nxt = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_mant      <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_e         <= '0;
            r_sub       <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sign      <= w_sign_nxt;
            r_mant      <= w_mant_nxt;
            r_guard     <= w_guard_nxt;
            r_sticky    <= w_sticky_nxt;
            r_e         <= w_e_nxt;
            r_sub       <= w_sub_nxt;
            r_result    <= w_result_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
            r_inexact   <= w_inexact_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp16_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_norm_round
// Description : Directed self-checking bench for fp16_norm_round.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_norm_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [11:0] mant_in;
    logic        guard_in;
    logic        sticky_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        s;
        logic [4:0]  e;
        logic [11:0] m;
        logic        g;
        logic        st;
        logic [15:0] r;
        logic [2:0]  flags;   // {overflow, underflow, inexact}
        int          cyc;
    } vec_t;

    fp16_norm_round #(
        .EXP_W  (5),
        .FRAC_W (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .guard_in  (guard_in),
        .sticky_in (sticky_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand, then count cycles until out_valid (accept cycle = 0)
    task automatic do_op(input logic s, input logic [4:0] e, input logic [11:0] m,
                         input logic g, input logic st, output int cyc, output bit to);
        @(negedge clk);
        in_valid  = 1'b1;
        sign_in   = s;
        exp_in    = e;
        mant_in   = m;
        guard_in  = g;
        sticky_in = st;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        to = !out_valid;
    endtask

    // Complete the output handshake with a single-cycle out_ready pulse
    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        if (result !== 16'h0000 || {overflow, underflow, inexact} !== 3'b000) begin
            bad++;
            $display("FAIL reset_out: result=%h flags=%b want 0000/000",
                     result, {overflow, underflow, inexact});
        end
    endtask

    task automatic test_datapath();
        vec_t v[14];
        int   cyc;
        bit   to;
        v[0]  = '{"normal",      1'b0, 5'd15, 12'h400, 1'b0, 1'b0, 16'h3C00, 3'b000, 3};
        v[1]  = '{"carry",       1'b0, 5'd15, 12'h800, 1'b0, 1'b0, 16'h4000, 3'b000, 4};
        v[2]  = '{"tie_odd",     1'b0, 5'd15, 12'h401, 1'b1, 1'b0, 16'h3C02, 3'b001, 3};
        v[3]  = '{"tie_even",    1'b0, 5'd15, 12'h400, 1'b1, 1'b0, 16'h3C00, 3'b001, 3};
        v[4]  = '{"above_half",  1'b0, 5'd15, 12'h400, 1'b1, 1'b1, 16'h3C01, 3'b001, 3};
        v[5]  = '{"overflow",    1'b0, 5'd30, 12'h7FF, 1'b1, 1'b1, 16'h7C00, 3'b101, 3};
        v[6]  = '{"subnormal",   1'b0, 5'd3,  12'h020, 1'b0, 1'b0, 16'h0080, 3'b000, 5};
        v[7]  = '{"neg_zero",    1'b1, 5'd10, 12'h000, 1'b0, 1'b0, 16'h8000, 3'b000, 2};
        v[8]  = '{"inf_nan",     1'b0, 5'd31, 12'h200, 1'b0, 1'b0, 16'h7E00, 3'b000, 1};
        v[9]  = '{"max_cancel",  1'b0, 5'd20, 12'h001, 1'b0, 1'b0, 16'h2800, 3'b000, 13};
        v[10] = '{"sub_inexact", 1'b0, 5'd0,  12'h001, 1'b1, 1'b1, 16'h0002, 3'b011, 3};
        v[11] = '{"sub_to_norm", 1'b0, 5'd0,  12'h3FF, 1'b1, 1'b0, 16'h0400, 3'b001, 3};
        v[12] = '{"neg_round",   1'b1, 5'd16, 12'h5FF, 1'b1, 1'b1, 16'hC200, 3'b001, 3};
        v[13] = '{"carry_round", 1'b0, 5'd15, 12'hFFF, 1'b1, 1'b0, 16'h4400, 3'b001, 4};
        for (int i = 0; i < 14; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, v[i].g, v[i].st, cyc, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL %s_timeout: out_valid=0 after %0d cycles, want 1 at %0d",
                         v[i].name, cyc, v[i].cyc);
            end
            total++;
            if (result !== v[i].r) begin
                bad++;
                $display("FAIL %s_result: got %h want %h", v[i].name, result, v[i].r);
            end
            total++;
            if ({overflow, underflow, inexact} !== v[i].flags) begin
                bad++;
                $display("FAIL %s_flags: got %b want %b (ovf,unf,inx)", v[i].name,
                         {overflow, underflow, inexact}, v[i].flags);
            end
            total++;
            if (cyc != v[i].cyc) begin
                bad++;
                $display("FAIL %s_latency: got %0d want %0d", v[i].name, cyc, v[i].cyc);
            end
            release_op();
        end
    endtask

    task automatic test_hold();
        int cyc;
        bit to;
        do_op(1'b0, 5'd15, 12'h401, 1'b1, 1'b0, cyc, to);
        // A competing operand offered while busy must be ignored
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            exp_in    = 5'd7;
            mant_in   = 12'h800;
            @(posedge clk);
            #1;
            total++;
            if (result !== 16'h3C02 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: result=%h out_valid=%b in_ready=%b want 3C02/1/0",
                         k, result, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        release_op();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        do_op(1'b0, 5'd15, 12'h800, 1'b0, 1'b0, cyc, to);
        release_op();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        do_op(1'b1, 5'd14, 12'h400, 1'b0, 1'b0, cyc, to);
        total++;
        if (to || result !== 16'hB800 || cyc != 3) begin
            bad++;
            $display("FAIL b2b_second: result=%h cyc=%0d want B800 at 3", result, cyc);
        end
        release_op();
    endtask

    task automatic test_reset_midop();
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        sign_in   = 1'b0;
        exp_in    = 5'd20;
        mant_in   = 12'h001;
        guard_in  = 1'b0;
        sticky_in = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midop_busy: in_ready=%b want 0", in_ready);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
            bad++;
            $display("FAIL midop_reset: out_valid=%b in_ready=%b result=%h want 0/1/0000",
                     out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_no_result: seen_valid=%b in_ready=%b want 0/1", seen, in_ready);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sign_in   = 1'b0;
        exp_in    = '0;
        mant_in   = '0;
        guard_in  = 1'b0;
        sticky_in = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_datapath();
        test_hold();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
